// File: rtl/funcion_lut_if.sv
// Bus bundle for funcion_lut: evaluation, serial table load and sweep self-check.
interface funcion_lut_if #(
  parameter int N_ENT = 3
);
  localparam int NT = 2**N_ENT;

  logic [N_ENT-1:0] ent;
  logic             z;
  logic             carga_ini;
  logic             dato_valido;
  logic             dato_serie;
  logic             carga_fin;
  logic             barrido_ini;
  logic [N_ENT-1:0] ent_barrido;
  logic             resp_ext;
  logic             ocupado;
  logic             barrido_fin;
  logic [NT-1:0]    resultado;
  logic             error;

  // LUT side
  modport slave (
    input  ent, carga_ini, dato_valido, dato_serie, barrido_ini, resp_ext,
    output z, carga_fin, ent_barrido, ocupado, barrido_fin, resultado, error
  );

  // Driver side
  modport master (
    output ent, carga_ini, dato_valido, dato_serie, barrido_ini, resp_ext,
    input  z, carga_fin, ent_barrido, ocupado, barrido_fin, resultado, error
  );
endinterface

// File: rtl/funcion_lut.sv
// Programmable N-input Boolean function (registered), serial table reload
// through a shadow register, and a sweep engine that checks an external block.
module funcion_lut #(
  parameter int                    N_ENT     = 3,
  parameter logic [(2**N_ENT)-1:0] TABLA_INI = 'h5C,
  parameter int                    LAT       = 1
) (
  input logic          clk,
  input logic          reset,
  funcion_lut_if.slave bus
);
  localparam int NT = 2**N_ENT;
  localparam int KW = $clog2(NT + LAT + 1);
  localparam logic [KW-1:0]    K_FIN = KW'(NT + LAT - 1);
  localparam logic [KW-1:0]    K_LAT = KW'(LAT);
  localparam logic [KW-1:0]    K_NT  = KW'(NT);
  localparam logic [N_ENT-1:0] B_ULT = N_ENT'(NT - 1);

  typedef enum logic [1:0] {REPOSO, CARGA, BARRIDO, FIN} estado_t;

  estado_t          estado_q, estado_d;
  logic [NT-1:0]    tabla_q, tabla_d;
  logic [NT-1:0]    sombra_q, sombra_d;
  logic [NT-1:0]    resultado_q, resultado_d;
  logic [N_ENT-1:0] bits_q, bits_d;
  logic [KW-1:0]    k_q, k_d;
  logic [N_ENT-1:0] ent_b_q, ent_b_d;
  logic [N_ENT-1:0] idx;
  logic             z_q;
  logic             carga_fin_q, carga_fin_d;
  logic             error_q, error_d;

  // Function evaluation runs in every state; the old table stays live until commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) z_q <= 1'b0;
    else       z_q <= tabla_q[bus.ent];
  end

  // Next state and datapath: CARGA shifts MSB-first, BARRIDO captures LAT clocks late
  always_comb begin
    estado_d    = estado_q;
    tabla_d     = tabla_q;
    sombra_d    = sombra_q;
    resultado_d = resultado_q;
    bits_d      = bits_q;
    k_d         = k_q;
    ent_b_d     = ent_b_q;
    carga_fin_d = 1'b0;
    error_d     = error_q;
    idx         = N_ENT'(k_q - K_LAT);
    case (estado_q)
      REPOSO: begin
        // Load wins a same-cycle collision; the sweep strobe is simply dropped
        if (bus.carga_ini) begin
          estado_d = CARGA;
          bits_d   = '0;
          sombra_d = '0;
        end else if (bus.barrido_ini) begin
          estado_d    = BARRIDO;
          k_d         = '0;
          ent_b_d     = '0;
          resultado_d = '0;
          error_d     = 1'b0;
        end
      end
      CARGA: begin
        if (bus.dato_valido) begin
          sombra_d = {sombra_q[NT-2:0], bus.dato_serie};
          bits_d   = bits_q + 1'b1;
          if (bits_q == B_ULT) begin
            // Commit includes the bit arriving on this very clock
            tabla_d     = {sombra_q[NT-2:0], bus.dato_serie};
            carga_fin_d = 1'b1;
            bits_d      = '0;
            estado_d    = REPOSO;
          end
        end
      end
      BARRIDO: begin
        k_d = k_q + 1'b1;
        // Stimulus stops advancing at the last code while late responses drain
        if (k_d < K_NT) ent_b_d = k_d[N_ENT-1:0];
        if (k_q >= K_LAT) resultado_d[idx] = bus.resp_ext;
        if (k_q == K_FIN) begin
          k_d      = '0;
          estado_d = FIN;
        end
      end
      FIN: begin
        error_d  = (resultado_q != tabla_q);
        estado_d = REPOSO;
      end
      default: estado_d = REPOSO;
    endcase
  end

  // State register; async reset drops any half-done load or sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= REPOSO;
      tabla_q     <= TABLA_INI;
      sombra_q    <= '0;
      resultado_q <= '0;
      bits_q      <= '0;
      k_q         <= '0;
      ent_b_q     <= '0;
      carga_fin_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      tabla_q     <= tabla_d;
      sombra_q    <= sombra_d;
      resultado_q <= resultado_d;
      bits_q      <= bits_d;
      k_q         <= k_d;
      ent_b_q     <= ent_b_d;
      carga_fin_q <= carga_fin_d;
      error_q     <= error_d;
    end
  end

  assign bus.z           = z_q;
  assign bus.carga_fin   = carga_fin_q;
  assign bus.ent_barrido = ent_b_q;
  assign bus.ocupado     = (estado_q != REPOSO);
  assign bus.barrido_fin = (estado_q == FIN);
  assign bus.resultado   = resultado_q;
  assign bus.error       = error_q;
endmodule

// File: tb/tb_funcion_lut.sv
// Bench for funcion_lut: scoreboarded evaluation, serial loads, sweeps against
// a reference LUT and a faulty LUT, strobe collisions and mid-operation reset.
module tb_funcion_lut;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  funcion_lut_if #(.N_ENT(3)) dut_if ();
  funcion_lut_if #(.N_ENT(3)) ref_if ();
  funcion_lut_if #(.N_ENT(3)) flt_if ();

  funcion_lut #(.N_ENT(3), .TABLA_INI(8'h5C), .LAT(1)) dut   (.clk(clk), .reset(reset), .bus(dut_if.slave));
  funcion_lut #(.N_ENT(3), .TABLA_INI(8'h5C), .LAT(1)) u_ref (.clk(clk), .reset(reset), .bus(ref_if.slave));
  funcion_lut #(.N_ENT(3), .TABLA_INI(8'h7C), .LAT(1)) u_flt (.clk(clk), .reset(reset), .bus(flt_if.slave));

  // External blocks are driven by the DUT sweep stimulus
  assign ref_if.ent = dut_if.ent_barrido;
  assign flt_if.ent = dut_if.ent_barrido;
  assign {ref_if.carga_ini, ref_if.dato_valido, ref_if.dato_serie, ref_if.barrido_ini, ref_if.resp_ext} = '0;
  assign {flt_if.carga_ini, flt_if.dato_valido, flt_if.dato_serie, flt_if.barrido_ini, flt_if.resp_ext} = '0;

  logic [1:0] resp_sel;  // 0: reference, 1: faulty (bit 5 stuck 1), 2: constant 1
  assign dut_if.resp_ext = (resp_sel == 2'd0) ? ref_if.z :
                           (resp_sel == 2'd1) ? flt_if.z : 1'b1;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
  } barr_t;

  logic  sb_z[$];
  barr_t sb_b[$];
  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] mt;  // model of the committed table

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_sel = 2'd0;
    dut_if.ent = '0; dut_if.carga_ini = 1'b0; dut_if.dato_valido = 1'b0;
    dut_if.dato_serie = 1'b0; dut_if.barrido_ini = 1'b0;
    tick(); tick();
    n_chk++;
    if ({dut_if.z, dut_if.carga_fin, dut_if.ocupado, dut_if.barrido_fin, dut_if.error} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000",
               {dut_if.z, dut_if.carga_fin, dut_if.ocupado, dut_if.barrido_fin, dut_if.error});
    else n_pass++;
    n_chk++;
    if ({dut_if.resultado, dut_if.ent_barrido} !== 11'b0)
      $display("FAIL reset_regs got resultado=%h ent_barrido=%0d exp 0/0", dut_if.resultado, dut_if.ent_barrido);
    else n_pass++;
    reset = 1'b0;
    mt = 8'h5C;
    tick();
  endtask

  task automatic test_eval(input string nm);
    logic e;
    for (int i = 0; i < 8; i++) begin
      dut_if.ent = 3'(i);
      sb_z.push_back(mt[i]);
      tick();
      e = sb_z.pop_front();
      n_chk++;
      if (dut_if.z !== e) $display("FAIL %s_z ent=%0d got %b exp %b", nm, i, dut_if.z, e);
      else n_pass++;
    end
  endtask

  task automatic test_sweep(input logic [1:0] sel, input string nm);
    logic [7:0] eres;
    barr_t e;
    int n;
    resp_sel = sel;
    eres = (sel == 2'd0) ? 8'h5C : (sel == 2'd1) ? 8'h7C : 8'hFF;
    sb_b.push_back({eres, (eres != mt)});
    dut_if.barrido_ini = 1'b1;
    tick();
    dut_if.barrido_ini = 1'b0;
    n_chk++;
    if ({dut_if.ocupado, dut_if.error, dut_if.resultado} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL %s_start got ocupado=%b error=%b resultado=%h exp 1/0/00",
               nm, dut_if.ocupado, dut_if.error, dut_if.resultado);
    else n_pass++;
    n = 0;
    while (dut_if.barrido_fin !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    n_chk++;
    if (n !== 9) $display("FAIL %s_latency got %0d exp 9", nm, n);
    else n_pass++;
    e = sb_b.pop_front();
    n_chk++;
    if (dut_if.resultado !== e.res) $display("FAIL %s_resultado got %h exp %h", nm, dut_if.resultado, e.res);
    else n_pass++;
    tick();
    n_chk++;
    if ({dut_if.error, dut_if.barrido_fin, dut_if.ocupado} !== {e.err, 2'b00})
      $display("FAIL %s_end got error=%b fin=%b ocupado=%b exp %b/0/0",
               nm, dut_if.error, dut_if.barrido_fin, dut_if.ocupado, e.err);
    else n_pass++;
    repeat (4) tick();
    n_chk++;
    if (dut_if.error !== e.err) $display("FAIL %s_error_hold got %b exp %b", nm, dut_if.error, e.err);
    else n_pass++;
  endtask

  task automatic test_load(input logic [7:0] val, input int stall_pos, input logic collide, input string nm);
    logic [7:0] old;
    logic e;
    int pulses;
    int bfin;
    old = mt; pulses = 0; bfin = 0;
    dut_if.carga_ini = 1'b1;
    dut_if.barrido_ini = collide;
    tick();
    dut_if.carga_ini = 1'b0;
    dut_if.barrido_ini = 1'b0;
    n_chk++;
    if (dut_if.ocupado !== 1'b1) $display("FAIL %s_ocupado_in got %b exp 1", nm, dut_if.ocupado);
    else n_pass++;
    for (int b = 7; b >= 0; b--) begin
      for (int s = 0; s < ((b == stall_pos) ? 4 : 1); s++) begin
        // the first (b == stall_pos) iterations are stalls, the last one shifts
        dut_if.dato_valido = (s == ((b == stall_pos) ? 3 : 0));
        dut_if.dato_serie  = val[b];
        dut_if.ent         = 3'(b);
        dut_if.barrido_ini = collide && (b == 3);
        sb_z.push_back(old[b]);
        tick();
        dut_if.barrido_ini = 1'b0;
        pulses += int'(dut_if.carga_fin);
        bfin   += int'(dut_if.barrido_fin);
        e = sb_z.pop_front();
        n_chk++;
        if (dut_if.z !== e) $display("FAIL %s_z_old bit=%0d got %b exp %b", nm, b, dut_if.z, e);
        else n_pass++;
      end
    end
    dut_if.dato_valido = 1'b0;
    n_chk++;
    if ({dut_if.carga_fin, dut_if.ocupado} !== 2'b10)
      $display("FAIL %s_commit got carga_fin=%b ocupado=%b exp 1/0", nm, dut_if.carga_fin, dut_if.ocupado);
    else n_pass++;
    repeat (12) begin
      tick();
      pulses += int'(dut_if.carga_fin);
      bfin   += int'(dut_if.barrido_fin) + int'(dut_if.ocupado);
    end
    n_chk++;
    if (pulses !== 1) $display("FAIL %s_carga_fin_pulses got %0d exp 1", nm, pulses);
    else n_pass++;
    n_chk++;
    if (bfin !== 0) $display("FAIL %s_no_sweep got %0d busy/fin cycles exp 0", nm, bfin);
    else n_pass++;
    mt = val;
    test_eval({nm, "_new"});
  endtask

  task automatic test_reset_carga();
    int pulses;
    pulses = 0;
    dut_if.carga_ini = 1'b1;
    tick();
    dut_if.carga_ini = 1'b0;
    dut_if.dato_valido = 1'b1;
    dut_if.dato_serie = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({dut_if.ocupado, dut_if.carga_fin} !== 2'b00)
      $display("FAIL rst_carga_state got ocupado=%b carga_fin=%b exp 0/0", dut_if.ocupado, dut_if.carga_fin);
    else n_pass++;
    tick();
    reset = 1'b0;
    repeat (6) begin
      tick();
      pulses += int'(dut_if.carga_fin);
    end
    dut_if.dato_valido = 1'b0;
    n_chk++;
    if (pulses !== 0) $display("FAIL rst_carga_pulses got %0d exp 0", pulses);
    else n_pass++;
    mt = 8'h5C;
    test_eval("rst_carga_tabla");
  endtask

  task automatic test_reset_barrido();
    int pulses;
    pulses = 0;
    resp_sel = 2'd2;
    dut_if.barrido_ini = 1'b1;
    tick();
    dut_if.barrido_ini = 1'b0;
    repeat (3) tick();
    n_chk++;
    if ({dut_if.resultado, dut_if.ent_barrido} !== {8'h03, 3'd3})
      $display("FAIL rst_barr_pre got resultado=%h ent_barrido=%0d exp 03/3", dut_if.resultado, dut_if.ent_barrido);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({dut_if.resultado, dut_if.error, dut_if.ocupado, dut_if.ent_barrido} !== 13'b0)
      $display("FAIL rst_barr_state got resultado=%h error=%b ocupado=%b ent_barrido=%0d exp 00/0/0/0",
               dut_if.resultado, dut_if.error, dut_if.ocupado, dut_if.ent_barrido);
    else n_pass++;
    tick();
    reset = 1'b0;
    repeat (15) begin
      tick();
      pulses += int'(dut_if.barrido_fin);
    end
    n_chk++;
    if (pulses !== 0) $display("FAIL rst_barr_pulses got %0d exp 0", pulses);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_eval("default");
    test_sweep(2'd0, "sweep_pass");
    test_sweep(2'd1, "sweep_fault");
    test_sweep(2'd0, "sweep_clear");
    test_load(8'hA5, 4, 1'b0, "load_stall");
    test_load(8'h3C, -1, 1'b1, "collision");
    test_reset_carga();
    test_reset_barrido();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
